// File: rtl/iter_shifter_pkg.sv
// Shared types for the iterative shifter: operation and FSM state encodings.
package iter_shifter_pkg;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_LSL = 2'b01,
        OP_LSR = 2'b10,
        OP_ASR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/result bundle of the iterative shifter.
// slave: seen from the shifter; master: seen from the producer/consumer.
interface iter_shifter_if
    import iter_shifter_pkg::*;
#(
    parameter int W = 16
);
    localparam int AMT_W = $clog2(W);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    shift_op_t        in_op;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             carry_out;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_op, in_amt, out_ready,
        output in_ready, out_valid, out_data, carry_out, busy
    );

    modport master (
        output in_valid, in_data, in_op, in_amt, out_ready,
        input  in_ready, out_valid, out_data, carry_out, busy
    );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// One combinational shift of n bits (0..STEP) and the last bit it pushes out.
// n == 0 passes the data through and reports no carry.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int W    = 16,
    parameter int STEP = 1
)(
    input  logic [W-1:0]               data_i,
    input  shift_op_t                  op_i,
    input  logic [$clog2(STEP+1)-1:0]  n_i,
    input  logic                       sign_i,
    output logic [W-1:0]               data_o,
    output logic                       carry_o
);
    logic [W:0]   lsl_d;
    logic [W:0]   rsh_d;
    logic [W-1:0] fill_mask;
    logic [W-1:0] ror_d;
    logic         raw_carry;

    // Left shift keeps one extra MSB for the carry, right shift one extra LSB.
    always_comb begin
        lsl_d     = {1'b0, data_i} << n_i;
        rsh_d     = {data_i, 1'b0} >> n_i;
        fill_mask = ~({W{1'b1}} >> n_i);
        ror_d     = (data_i >> n_i) | (data_i << (W - int'(n_i)));
        data_o    = '0;
        raw_carry = 1'b0;
        case (op_i)
            OP_LSL: begin
                data_o    = lsl_d[W-1:0];
                raw_carry = lsl_d[W];
            end
            OP_LSR: begin
                data_o    = rsh_d[W:1];
                raw_carry = rsh_d[0];
            end
            OP_ASR: begin
                data_o    = rsh_d[W:1] | (sign_i ? fill_mask : '0);
                raw_carry = rsh_d[0];
            end
            default: begin
                data_o    = ror_d;
                raw_carry = ror_d[W-1];
            end
        endcase
        carry_o = (n_i != '0) && raw_carry;
    end
endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: STEP bits per clock, result held until taken.
// Optional carry register: define SHIFTER_CARRY_EN.
//
// state   | meaning
// S_IDLE  | waiting for a request, in_ready high
// S_SHIFT | applying min(STEP, rem) per clock; a zero amount spends one cycle here
// S_DONE  | result held, out_valid high until out_ready
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int W    = 16,
    parameter int STEP = 1
)(
    input  logic           clk,
    input  logic           reset,
    iter_shifter_if.slave  bus
);
    localparam int AMT_W = $clog2(W);
    localparam int NW    = $clog2(STEP + 1);

    state_t           state_q;
    logic [W-1:0]     data_q;
    shift_op_t        op_q;
    logic [AMT_W-1:0] rem_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [NW-1:0]    step_n;
    logic             step_last;
    logic [W-1:0]     step_data;
    logic             step_carry;

    // Bits to move this cycle; the last step is the one that empties rem.
    always_comb begin
        step_last = (int'(rem_q) <= STEP);
        if (step_last) begin
            step_n = NW'(rem_q);
        end else begin
            step_n = NW'(STEP);
        end
    end

    // ASR fill comes from the data MSB, which never changes during an ASR.
    shift_step #(
        .W    (W),
        .STEP (STEP)
    ) u_step (
        .data_i  (data_q),
        .op_i    (op_q),
        .n_i     (step_n),
        .sign_i  (data_q[W-1]),
        .data_o  (step_data),
        .carry_o (step_carry)
    );

    // Control FSM with registered handshake outputs and the data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            op_q        <= OP_ROR;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        data_q     <= bus.in_data;
                        op_q       <= bus.in_op;
                        rem_q      <= bus.in_amt;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data_q <= step_data;
                    rem_q  <= rem_q - AMT_W'(step_n);
                    if (step_last) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFTER_CARRY_EN
    logic carry_q;

    // Carry cleared on accept, loaded once from the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.in_valid) begin
            carry_q <= 1'b0;
        end else if (state_q == S_SHIFT && step_last) begin
            carry_q <= step_carry;
        end
    end

    assign bus.carry_out = carry_q;
`else
    logic unused_step_carry;
    assign unused_step_carry = step_carry;
    assign bus.carry_out     = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;
endmodule
